multiword_sub_sequencer: RTL and testbench

- Multi-cycle controller that computes a wide subtraction using one WORD_W-bit subtract slice per cycle, chaining the borrow from word to word, LSW first.
- Lets the FIR datapath subtract wide accumulator or tap values without a full-width subtractor: area is traded for NUM_WORDS cycles of latency.
- Valid/ready handshake on both sides, so it drops into the existing pipelined datapath.

---
 rtl/multiword_sub_sequencer.sv | 114 +++++++++++
 tb/tb_multiword_sub_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multiword_sub_sequencer.sv
// Wide subtractor built from one WORD_W-bit slice per cycle, LSW first, with the borrow
// chained between words. There is a valid/ready handshake on both the request and result sides.
module multiword_sub_sequencer #(
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [WORD_W*NUM_WORDS-1:0] in1,
    input  logic [WORD_W*NUM_WORDS-1:0] in2,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*NUM_WORDS-1:0] diff,
    output logic                        borrow_out,
    output logic                        busy
);

    localparam int unsigned N    = WORD_W * NUM_WORDS;
    localparam int unsigned CntW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic            bout_q, bout_d;
    logic [WORD_W-1:0] a_word, b_word;
    logic [WORD_W:0]   slice;

    // Select the current word with a constant-indexed loop, so no variable part-selects are needed.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CntW'(k)) begin
                a_word = a_q[k*WORD_W +: WORD_W];
                b_word = b_q[k*WORD_W +: WORD_W];
            end
        end
        slice = {1'b0, a_word} - {1'b0, b_word} - {{WORD_W{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d      = in1;
                    b_d      = in2;
                    borrow_d = cin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (cnt_q == CntW'(k)) diff_d[k*WORD_W +: WORD_W] = slice[WORD_W-1:0];
                end
                borrow_d = slice[WORD_W];
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    bout_d  = slice[WORD_W];
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        out_valid   = (state_q == StDone);
        diff        = diff_q;
        borrow_out  = bout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

endmodule

// File: tb/tb_multiword_sub_sequencer.sv
// Self-checking bench: directed vectors on the 4x4 instance against a timeline/arithmetic model,
// plus a boundary-value sweep on a 2x4 instance with random result backpressure.
module tb_multiword_sub_sequencer;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0, start_ready, cin = 1'b0;
    logic [15:0] in1 = '0, in2 = '0, diff;
    logic        out_valid, out_ready = 1'b0, borrow_out, busy;

    logic        sv2 = 1'b0, sr2, c2 = 1'b0, ov2, or2 = 1'b0, bo2, busy2;
    logic [7:0]  a2 = '0, b2 = '0, d2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multiword_sub_sequencer #(.WORD_W(4), .NUM_WORDS(NW)) u_dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .in1(in1), .in2(in2), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .busy(busy)
    );

    multiword_sub_sequencer #(.WORD_W(4), .NUM_WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
        .in1(a2), .in2(b2), .cin(c2), .out_valid(ov2), .out_ready(or2),
        .diff(d2), .borrow_out(bo2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    // Model of the 4-word instance: idle / busy for NW cycles / holding a result.
    int          ph = 0;
    int          left = 0;
    logic [16:0] exp_res = '0;

    always @(posedge clk) begin
        if (rst) ph = 0;
        else if (ph == 0) begin
            if (start_valid) begin
                exp_res = {1'b0, in1} - {1'b0, in2} - 17'(cin);
                left = NW;
                ph = 1;
            end
        end else if (ph == 1) begin
            left--;
            if (left == 0) ph = 2;
        end else if (out_ready) ph = 0;
        #1;
        chk("model_start_ready", start_ready, ph == 0);
        chk("model_busy", busy, ph != 0);
        chk("model_out_valid", out_valid, ph == 2);
        if (ph == 2) chk("model_result", {borrow_out, diff}, exp_res);
    end

    // Scoreboard for the 2-word instance.
    logic [8:0] q2[$];
    int n_acc = 0;
    int n_res = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (ov2 && or2) begin
                if (q2.size() == 0) fail("sweep_extra_result");
                else chk("sweep_result", {bo2, d2}, q2.pop_front());
                n_res++;
            end
            if (sv2 && sr2) begin
                q2.push_back({1'b0, a2} - {1'b0, b2} - 9'(c2));
                n_acc++;
            end
        end
    end

    always @(negedge clk) or2 = ($urandom_range(0, 3) != 0);

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] ed, input logic eb);
        @(negedge clk);
        in1 = a; in2 = b; cin = c; start_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("lat_not_early", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1'b1);
        chk("op_diff", diff, ed);
        chk("op_borrow", borrow_out, eb);
        @(posedge clk);
        #1 chk("ready_again", start_ready, 1'b1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_diff", diff, 16'h0000);
        chk("rst_borrow", borrow_out, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start_ready", start_ready, 1'b1);
    endtask

    logic [7:0] vals[18] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h11, 8'h7F, 8'h80, 8'h81,
                             8'hEF, 8'hF0, 8'hFE, 8'hFF, 8'h3C, 8'h5A, 8'hA5, 8'hC3, 8'h96};

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_op(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure with a request waiting behind the held result.
        @(negedge clk);
        out_ready = 1'b0; in1 = 16'h5555; in2 = 16'h1111; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in1 = 16'h0300; in2 = 16'h0100;
        repeat (4) @(posedge clk);
        #1 chk("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_diff_stable", diff, 16'h4444);
            chk("bp_no_accept", start_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", out_valid, 1'b0);
        chk("bp_idle", start_ready, 1'b1);
        @(posedge clk);
        #1 chk("bp_pending_accepted", busy, 1'b1);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp2_valid", out_valid, 1'b1);
        chk("bp2_diff", diff, 16'h0200);

        // Reset while counter is 2 in RUN.
        @(negedge clk);
        in1 = 16'hAAAA; in2 = 16'h1111; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0);

        // Boundary-value sweep on the 2-word instance.
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < 18; j++) begin
                for (int c = 0; c < 2; c++) begin
                    int w;
                    @(negedge clk);
                    a2 = vals[i]; b2 = vals[j]; c2 = c[0]; sv2 = 1'b1;
                    w = 0;
                    while (!sr2 && w < 20) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 20) fail("sweep_accept_timeout");
                end
            end
        end
        @(negedge clk);
        sv2 = 1'b0;
        for (int w = 0; w < 100 && (q2.size() != 0 || busy2); w++) @(negedge clk);
        chk("sweep_drained", q2.size(), 0);
        chk("sweep_no_drop_dup", n_res, n_acc);
        chk("sweep_accept_count", n_acc, 18 * 18 * 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
